// File: rtl/loot_grab_if.sv
// loot_grab_if: claw-side and hit-detection signals of the loot grab controller.
// master drives claw/hit inputs, slave is the controller.
interface loot_grab_if #(parameter int NUM_LOOT = 8);
  localparam int IDW = $clog2(NUM_LOOT);
  logic                startOfFrame;
  logic                start_level;
  logic                hit_raw;
  logic [IDW-1:0]      hit_id;
  logic signed [10:0]  claw_topLeftX;
  logic signed [10:0]  claw_topLeftY;
  logic                claw_returned;
  logic                claw_collision;
  logic [3:0]          move_speed;
  logic                carry_valid;
  logic [IDW-1:0]      carry_id;
  logic signed [10:0]  loot_topLeftX;
  logic signed [10:0]  loot_topLeftY;
  logic [NUM_LOOT-1:0] loot_alive;
  logic                loot_collected;
  logic [9:0]          score_add;
  modport master (
    output startOfFrame, start_level, hit_raw, hit_id, claw_topLeftX, claw_topLeftY, claw_returned,
    input  claw_collision, move_speed, carry_valid, carry_id, loot_topLeftX, loot_topLeftY,
           loot_alive, loot_collected, score_add
  );
  modport slave (
    input  startOfFrame, start_level, hit_raw, hit_id, claw_topLeftX, claw_topLeftY, claw_returned,
    output claw_collision, move_speed, carry_valid, carry_id, loot_topLeftX, loot_topLeftY,
           loot_alive, loot_collected, score_add
  );
endinterface

// File: rtl/loot_grab_ctrl.sv
// loot_grab_ctrl: latches the hit loot, sets reel-in speed from its class,
// drags it with the claw each frame and awards score when the claw is back.
module loot_grab_ctrl #(
  parameter int                      NUM_LOOT      = 8,
  parameter logic [2*NUM_LOOT-1:0]   LOOT_CLASS    = '0,
  parameter logic [3:0]              DEFAULT_SPEED = 4'd4,
  parameter logic signed [10:0]      OFFSET_X      = 11'sd0,
  parameter logic signed [10:0]      OFFSET_Y      = 11'sd16
) (
  input logic        clk,
  input logic        resetN,
  loot_grab_if.slave lg
);
  localparam int IDW = $clog2(NUM_LOOT);
  localparam logic [3:0] SPEED [4] = '{4'd4, 4'd1, 4'd2, 4'd8};
  localparam logic [9:0] VALUE [4] = '{10'd50, 10'd250, 10'd10, 10'd500};
  typedef enum logic [1:0] {IDLE, LATCH, CARRY, AWARD} state_e;
  state_e              state_q, state_d;
  logic [IDW-1:0]      lid_q, lid_d, cid_q, cid_d;
  logic                cv_q, cv_d, coll_q, coll_d, col_q, col_d;
  logic [3:0]          spd_q, spd_d;
  logic signed [10:0]  lx_q, lx_d, ly_q, ly_d;
  logic [NUM_LOOT-1:0] alive_q, alive_d;
  logic [9:0]          score_q, score_d;
  logic [1:0]          cls;
  logic signed [10:0]  px, py;
  assign cls = LOOT_CLASS[{lid_q, 1'b0} +: 2];
  assign px  = lg.claw_topLeftX + OFFSET_X;
  assign py  = lg.claw_topLeftY + OFFSET_Y;
  always_comb begin
    state_d = state_q;
    lid_d   = lid_q;
    cid_d   = cid_q;
    cv_d    = cv_q;
    coll_d  = coll_q;
    spd_d   = spd_q;
    lx_d    = lx_q;
    ly_d    = ly_q;
    alive_d = alive_q;
    col_d   = 1'b0;
    score_d = '0;
    if (lg.start_level) begin
      state_d = IDLE;
      lid_d   = '0;
      cid_d   = '0;
      cv_d    = 1'b0;
      coll_d  = 1'b0;
      spd_d   = DEFAULT_SPEED;
      lx_d    = '0;
      ly_d    = '0;
      alive_d = '1;
    end else begin
      case (state_q)
        IDLE: if (!lg.claw_returned && lg.hit_raw && alive_q[lg.hit_id]) begin
          lid_d   = lg.hit_id;
          state_d = LATCH;
        end
        // collision and speed are loaded together so the claw never sees a stale speed
        LATCH: begin
          cid_d   = lid_q;
          cv_d    = 1'b1;
          spd_d   = SPEED[cls];
          lx_d    = px;
          ly_d    = py;
          coll_d  = 1'b1;
          state_d = CARRY;
        end
        CARRY: begin
          if (lg.startOfFrame) begin
            coll_d = 1'b0;
            lx_d   = px;
            ly_d   = py;
          end
          if (lg.claw_returned) begin
            col_d          = 1'b1;
            score_d        = VALUE[cls];
            alive_d[lid_q] = 1'b0;
            cv_d           = 1'b0;
            coll_d         = 1'b0;
            spd_d          = DEFAULT_SPEED;
            state_d        = AWARD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= IDLE;
      lid_q   <= '0;
      cid_q   <= '0;
      cv_q    <= 1'b0;
      coll_q  <= 1'b0;
      spd_q   <= DEFAULT_SPEED;
      lx_q    <= '0;
      ly_q    <= '0;
      alive_q <= '1;
      col_q   <= 1'b0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      lid_q   <= lid_d;
      cid_q   <= cid_d;
      cv_q    <= cv_d;
      coll_q  <= coll_d;
      spd_q   <= spd_d;
      lx_q    <= lx_d;
      ly_q    <= ly_d;
      alive_q <= alive_d;
      col_q   <= col_d;
      score_q <= score_d;
    end
  assign lg.claw_collision = coll_q;
  assign lg.move_speed     = spd_q;
  assign lg.carry_valid    = cv_q;
  assign lg.carry_id       = cid_q;
  assign lg.loot_topLeftX  = lx_q;
  assign lg.loot_topLeftY  = ly_q;
  assign lg.loot_alive     = alive_q;
  assign lg.loot_collected = col_q;
  assign lg.score_add      = score_q;
endmodule

// File: tb/tb_loot_grab_ctrl.sv
// tb_loot_grab_ctrl: directed claw scenarios plus random traffic, checked each
// cycle against a grab/deliver model of the loot controller.
module tb_loot_grab_ctrl;
  localparam logic [15:0] CLS = 16'hE4E4;
  logic clk = 1'b0;
  logic resetN;
  int   errors = 0;
  int   checks = 0;
  loot_grab_if #(.NUM_LOOT(8)) lg ();
  loot_grab_ctrl #(.LOOT_CLASS(CLS)) dut (.clk(clk), .resetN(resetN), .lg(lg));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, $signed(act), $signed(exp));
    end
  endtask
  function automatic int cls_of(input int id);
    return (int'(CLS) >> (2 * id)) & 3;
  endfunction
  function automatic int speed_of(input int c);
    return c == 0 ? 4 : c == 1 ? 1 : c == 2 ? 2 : 8;
  endfunction
  function automatic int value_of(input int c);
    return c == 0 ? 50 : c == 1 ? 250 : c == 2 ? 10 : 500;
  endfunction
  // model: m_id<0 means the claw is empty; m_age counts edges since the grab
  int                 m_id, m_age;
  bit                 m_award;
  logic               e_coll, e_cv, e_col;
  logic [3:0]         e_spd;
  logic [2:0]         e_cid;
  logic signed [10:0] e_lx, e_ly;
  logic [7:0]         e_alive;
  logic [9:0]         e_score;
  function automatic void m_reset();
    m_id = -1; m_age = 0; m_award = 0;
    e_coll = 0; e_cv = 0; e_col = 0; e_spd = 4; e_cid = 0;
    e_lx = 0; e_ly = 0; e_alive = 8'hFF; e_score = 0;
  endfunction
  function automatic void m_follow();
    e_lx = 11'(int'(lg.claw_topLeftX));
    e_ly = 11'(int'(lg.claw_topLeftY) + 16);
  endfunction
  always @(posedge clk) begin
    if (!resetN || lg.start_level) m_reset();
    else begin
      e_col = 0;
      e_score = 0;
      if (m_award) m_award = 0;
      else if (m_id < 0) begin
        if (!lg.claw_returned && lg.hit_raw && e_alive[lg.hit_id]) begin
          m_id = int'(lg.hit_id);
          m_age = 0;
        end
      end else if (m_age == 0) begin
        e_cid = 3'(m_id); e_cv = 1; e_coll = 1;
        e_spd = 4'(speed_of(cls_of(m_id)));
        m_follow();
        m_age = 1;
      end else begin
        if (lg.startOfFrame) begin
          e_coll = 0;
          m_follow();
        end
        if (lg.claw_returned) begin
          e_col = 1; e_score = 10'(value_of(cls_of(m_id)));
          e_alive[m_id] = 0; e_cv = 0; e_coll = 0; e_spd = 4;
          m_id = -1; m_award = 1;
        end
      end
    end
    #1;
    chk("claw_collision", 32'(lg.claw_collision), 32'(e_coll));
    chk("move_speed", 32'(lg.move_speed), 32'(e_spd));
    chk("carry_valid", 32'(lg.carry_valid), 32'(e_cv));
    chk("carry_id", 32'(lg.carry_id), 32'(e_cid));
    chk("loot_topLeftX", 32'(lg.loot_topLeftX), 32'(e_lx));
    chk("loot_topLeftY", 32'(lg.loot_topLeftY), 32'(e_ly));
    chk("loot_alive", 32'(lg.loot_alive), 32'(e_alive));
    chk("loot_collected", 32'(lg.loot_collected), 32'(e_col));
    chk("score_add", 32'(lg.score_add), 32'(e_score));
  end
  task automatic quiet();
    lg.startOfFrame = 0; lg.start_level = 0; lg.hit_raw = 0; lg.claw_returned = 0;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    resetN = 0;
    quiet();
    lg.hit_id = 0; lg.claw_topLeftX = 0; lg.claw_topLeftY = 0;
    cyc(3);
    chk("rst_speed", 32'(lg.move_speed), 4);
    chk("rst_alive", 32'(lg.loot_alive), 32'hFF);
    chk("rst_carry_valid", 32'(lg.carry_valid), 0);
    resetN = 1;
    cyc(1);
    lg.hit_raw = 1; lg.hit_id = 1;
    cyc(1); lg.hit_raw = 0;
    cyc(1);
    chk("grab_collision", 32'(lg.claw_collision), 1);
    chk("grab_speed", 32'(lg.move_speed), 1);
    chk("grab_id", 32'(lg.carry_id), 1);
    chk("grab_valid", 32'(lg.carry_valid), 1);
    lg.claw_topLeftX = 300; lg.claw_topLeftY = 120; lg.startOfFrame = 1;
    cyc(1); lg.startOfFrame = 0;
    chk("follow_x", 32'(lg.loot_topLeftX), 300);
    chk("follow_y", 32'(lg.loot_topLeftY), 136);
    chk("sof_collision_drop", 32'(lg.claw_collision), 0);
    lg.claw_topLeftX = 310; lg.claw_topLeftY = 130;
    cyc(1);
    chk("hold_x", 32'(lg.loot_topLeftX), 300);
    lg.claw_returned = 1;
    cyc(1); lg.claw_returned = 0;
    chk("award_pulse", 32'(lg.loot_collected), 1);
    chk("award_score", 32'(lg.score_add), 250);
    chk("award_alive", 32'(lg.loot_alive), 32'hFD);
    chk("award_speed", 32'(lg.move_speed), 4);
    cyc(1);
    chk("after_pulse", 32'(lg.loot_collected), 0);
    chk("after_score", 32'(lg.score_add), 0);
    lg.hit_raw = 1; lg.hit_id = 1;
    cyc(1); lg.hit_raw = 0;
    cyc(1);
    chk("dead_hit_collision", 32'(lg.claw_collision), 0);
    chk("dead_hit_valid", 32'(lg.carry_valid), 0);
    lg.hit_raw = 1; lg.hit_id = 3; lg.claw_returned = 1;
    cyc(1); quiet();
    cyc(1);
    chk("ret_beats_hit", 32'(lg.carry_valid), 0);
    lg.hit_raw = 1; lg.hit_id = 3;
    cyc(1); lg.hit_raw = 0;
    cyc(1);
    chk("diamond_speed", 32'(lg.move_speed), 8);
    lg.hit_raw = 1; lg.hit_id = 2;
    cyc(1); lg.hit_raw = 0;
    cyc(1);
    chk("carry_ignores_hit", 32'(lg.carry_id), 3);
    lg.start_level = 1;
    cyc(1); lg.start_level = 0;
    chk("restart_valid", 32'(lg.carry_valid), 0);
    chk("restart_speed", 32'(lg.move_speed), 4);
    chk("restart_alive", 32'(lg.loot_alive), 32'hFF);
    lg.claw_topLeftX = -5; lg.claw_topLeftY = 1030; lg.hit_raw = 1; lg.hit_id = 0;
    cyc(1); lg.hit_raw = 0;
    cyc(1);
    chk("wrap_y", 32'(lg.loot_topLeftY), -1002);
    chk("neg_x", 32'(lg.loot_topLeftX), -5);
    #3 resetN = 0;
    #1;
    chk("async_rst_valid", 32'(lg.carry_valid), 0);
    chk("async_rst_y", 32'(lg.loot_topLeftY), 0);
    cyc(2);
    resetN = 1;
    for (int i = 0; i < 8; i++) begin
      lg.hit_raw = 1; lg.hit_id = 3'(i);
      cyc(1); lg.hit_raw = 0;
      cyc(1); lg.claw_returned = 1;
      cyc(1); lg.claw_returned = 0;
      cyc(1);
    end
    chk("all_dead", 32'(lg.loot_alive), 0);
    lg.hit_raw = 1; lg.hit_id = 5;
    cyc(2); lg.hit_raw = 0;
    chk("all_dead_absorb", 32'(lg.carry_valid), 0);
    lg.start_level = 1;
    cyc(1);
    for (int i = 0; i < 3000; i++) begin
      lg.start_level   = ($urandom_range(199) == 0);
      lg.hit_raw       = ($urandom_range(2) == 0);
      lg.hit_id        = 3'($urandom_range(7));
      lg.startOfFrame  = ($urandom_range(5) == 0);
      lg.claw_returned = ($urandom_range(7) == 0);
      lg.claw_topLeftX = 11'($urandom);
      lg.claw_topLeftY = 11'($urandom);
      cyc(1);
    end
    quiet();
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/loot_grab_ctrl.md
Name: loot_grab_ctrl

Overview:
- Responder side of the claw interface: consumes claw position, raw hit detection and claw_returned; produces claw_collision and move_speed for the claw motion block.
- Latches which loot was hit and selects the reel-in speed from that loot's weight class.
- Drags the loot with the claw each frame and pulses score/removal when the claw is back at the top.
- Sits between the loot hit-detection logic and the claw motion block; feeds the score counter and loot drawers.

Parameters:
- NUM_LOOT, 8, number of loot objects; one alive bit per object.
- LOOT_CLASS, 16'h0000, 2 bits per loot id; bits [2i+1:2i] give the class of loot i.
- DEFAULT_SPEED, 4'd4, move_speed when nothing is carried.
- OFFSET_X, 11'sd0, signed X offset from claw top-left to carried loot top-left.
- OFFSET_Y, 11'sd16, signed Y offset from claw top-left to carried loot top-left.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at frame start (30 Hz)
- start_level  in  1  synchronous level restart: all loot alive, state cleared
- hit_raw  in  1  claw overlaps some loot this cycle
- hit_id  in  3  id of overlapped loot; valid with hit_raw
- claw_topLeftX  in  11 signed  claw position X
- claw_topLeftY  in  11 signed  claw position Y
- claw_returned  in  1  claw back at swing origin
- claw_collision  out  1  collision indication to claw
- move_speed  out  4  claw linear speed
- carry_valid  out  1  a loot is attached to the claw
- carry_id  out  3  id of attached loot
- loot_topLeftX  out  11 signed  attached loot position X
- loot_topLeftY  out  11 signed  attached loot position Y
- loot_alive  out  NUM_LOOT  per-loot alive mask (drawers hide dead loot)
- loot_collected  out  1  one-cycle pulse when loot is delivered
- score_add  out  10  points for the delivered loot; valid with loot_collected, 0 otherwise

Behaviour:
- Reset and start_level give identical values: state IDLE, claw_collision=0, move_speed=DEFAULT_SPEED, carry_valid=0, carry_id=0, loot_topLeft*=0, loot_alive=all ones, loot_collected=0, score_add=0. Reset is async; start_level is sampled on clk and has priority over all other inputs.
- Class table (speed, value): 0 = small gold (4, 50); 1 = big gold (1, 250); 2 = rock (2, 10); 3 = diamond (8, 500).
- States: IDLE, LATCH, CARRY, AWARD. All outputs are registered.
- IDLE:
  - claw_returned=1 keeps IDLE (empty return); it beats a same-cycle hit_raw.
  - Otherwise hit_raw=1 with loot_alive[hit_id]=1 registers hit_id and goes to LATCH.
  - A hit on dead loot is ignored.
- LATCH (exactly 1 cycle):
  - carry_id set, carry_valid=1, move_speed=class speed.
  - loot_topLeft = claw_topLeft + offset.
  - claw_collision=1. Go to CARRY.
- claw_collision and move_speed change on the same clock edge, so the claw never sees the collision with a stale speed.
- CARRY:
  - claw_collision stays 1 until the first startOfFrame seen in CARRY, inclusive, then drops to 0 on the next cycle. This guarantees the claw samples it during its wait phase.
  - On each startOfFrame, loot_topLeft = claw_topLeft + offset; the position holds between frames.
  - hit_raw is ignored.
  - claw_returned=1 goes to AWARD.
- AWARD (exactly 1 cycle):
  - loot_collected=1, score_add=class value, loot_alive[carry_id] cleared.
  - carry_valid=0, claw_collision=0, move_speed=DEFAULT_SPEED.
  - Return to IDLE; score_add returns to 0 next cycle.
- Latency:
  - hit_raw to claw_collision/move_speed: 2 cycles.
  - claw_returned to loot_collected: 1 cycle.
- Offset sums are 11-bit signed and wrap on overflow, with no saturation.
- At most one loot is carried at a time. When all loot is dead, IDLE absorbs every hit.
- Reset or start_level mid-CARRY drops the loot with no score, and the loot is alive again.

Test Plan:
- Reset, then hit_raw=1, hit_id=1, LOOT_CLASS[3:2]=1 -> 2 cycles later claw_collision=1, move_speed=1, carry_id=1, carry_valid=1.
- From CARRY, claw moves to (300,120) and startOfFrame pulses -> loot_topLeft=(300,136); claw_collision=0 on the following cycle.
- In CARRY, claw_returned=1 -> next cycle loot_collected=1, score_add=250, loot_alive[1]=0, move_speed=4; all three return to idle values (pulse 0, score 0) one cycle later.
- Hit on loot 1 again after it is collected -> no state change, claw_collision stays 0.
- hit_raw and claw_returned together in IDLE -> stays IDLE; second hit_raw on a class-3 loot in CARRY is ignored.
- start_level asserted mid-CARRY (diamond) -> next cycle carry_valid=0, move_speed=4, loot_alive=8'hFF, loot_collected never pulses.
